// File: rtl/atx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between the CPU port (req 0)
// and the trace source (req 1), and runs the transmitter load/busy handshake.
module atx_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 255,
  parameter int TMR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  uart_busy,
  output logic                  uart_load,
  output logic [DATA_WIDTH-1:0] uart_data,
  output logic                  grant_id,
  output logic                  idle,
  output logic                  ack_err,
  input  logic                  ack_err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 ptr;
  logic [TMR_WIDTH-1:0] timer;
  logic                 accept, winner, timeout, stay_load;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    winner    = ptr;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (!uart_busy && (req0_valid || req1_valid)) begin
          accept    = 1'b1;
          // ptr names the favoured requester when both ask at once
          winner    = (req0_valid && req1_valid) ? ptr : req1_valid;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (uart_busy) begin
          state_nxt = SEND;
        end else if (timer == TMR_WIDTH'(ACK_TIMEOUT)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      SEND: begin
        if (!uart_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // load is registered, so it rises one cycle after the ready pulse
  assign stay_load = (state == LOAD) && (state_nxt == LOAD);
  assign idle      = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      timer      <= '0;
      uart_load  <= 1'b0;
      uart_data  <= '0;
      grant_id   <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      req0_ready <= accept && !winner;
      req1_ready <= accept && winner;
      uart_load  <= stay_load;
      if (accept) begin
        uart_data <= winner ? req1_data : req0_data;
        grant_id  <= winner;
        ptr       <= ~winner;
        timer     <= '0;
      end else if (stay_load) begin
        timer <= timer + 1'b1;
      end
      if (timeout)          ack_err <= 1'b1;
      else if (ack_err_clr) ack_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_atx_arbiter.sv
// Directed bench for atx_arbiter: a per-cycle vector table for a single byte,
// then hand-written sequences for contention, blocking, timeout, reset and withdrawal.
module tb_atx_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       uart_busy, uart_load, grant_id, idle, ack_err;
  logic [7:0] uart_data;
  logic       ack_err_clr = 1'b0;
  logic       busy_drv = 1'b0, tx_en = 1'b0;
  logic       mb;
  logic [1:0] mcnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  atx_arbiter #(.DATA_WIDTH(8), .ACK_TIMEOUT(8), .TMR_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .uart_busy(uart_busy), .uart_load(uart_load), .uart_data(uart_data),
    .grant_id(grant_id), .idle(idle), .ack_err(ack_err), .ack_err_clr(ack_err_clr)
  );

  // transmitter model: busy one cycle after load is seen, held for 4 cycles
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mb   <= 1'b0;
      mcnt <= 2'd0;
    end else if (!mb && uart_load) begin
      mb   <= 1'b1;
      mcnt <= 2'd3;
    end else if (mb) begin
      if (mcnt == 2'd0) mb <= 1'b0;
      else              mcnt <= mcnt - 2'd1;
    end
  end
  assign uart_busy = tx_en ? mb : busy_drv;

  typedef struct {
    logic        v0, v1, busy, clr;
    logic [7:0]  d0, d1;
    logic [13:0] exp;   // {r0, r1, load, data, gid, idle, err}
  } vec_t;
  vec_t tbl[$];

  function automatic logic [13:0] obs();
    return {req0_ready, req1_ready, uart_load, uart_data, grant_id, idle, ack_err};
  endfunction

  function automatic void add(input logic v0, input logic [7:0] d0, input logic busy,
                              input logic [13:0] exp);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.v1 = 1'b0; v.d1 = 8'h00; v.busy = busy; v.clr = 1'b0;
    v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; ack_err_clr = 1'b0;
    busy_drv = 1'b0; tx_en = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] got_d[6];
    logic       got_g[6];
    logic [7:0] exp_d[6];
    logic       exp_g[6];
    int got, n0, n1, hi, bad, found;

    // single byte 0x41; busy rises 3 cycles after load and holds 10 cycles
    add(1'b1, 8'h41, 1'b0, {3'b100, 8'h41, 3'b000});
    for (int i = 0; i < 4; i++)  add(1'b0, 8'h41, 1'b0, {3'b001, 8'h41, 3'b000});
    for (int i = 0; i < 10; i++) add(1'b0, 8'h41, 1'b1, {3'b000, 8'h41, 3'b000});
    add(1'b0, 8'h41, 1'b0, {3'b000, 8'h41, 3'b010});
    add(1'b0, 8'h41, 1'b0, {3'b000, 8'h41, 3'b010});

    do_reset();
    chk("reset_state", 32'(obs()), 32'({3'b000, 8'h00, 3'b010}));

    foreach (tbl[i]) begin
      req0_valid = tbl[i].v0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_data = tbl[i].d1;
      busy_drv = tbl[i].busy; ack_err_clr = tbl[i].clr;
      step();
      chk($sformatf("single_row%0d", i), 32'(obs()), 32'(tbl[i].exp));
    end

    // contention: alternating service starting with requester 0
    do_reset();
    exp_d = '{8'h30, 8'h61, 8'h31, 8'h62, 8'h32, 8'h63};
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tx_en = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h30;
    req1_valid = 1'b1; req1_data = 8'h61;
    got = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 400 && got < 6; c++) begin
      step();
      if (req0_ready || req1_ready) begin
        got_d[got] = uart_data; got_g[got] = grant_id; got++;
        if (req0_ready) begin
          n0++;
          if (n0 == 3) req0_valid = 1'b0; else req0_data = req0_data + 8'd1;
        end
        if (req1_ready) begin
          n1++;
          if (n1 == 3) req1_valid = 1'b0; else req1_data = req1_data + 8'd1;
        end
      end
    end
    chk("contention_count", 32'(got), 32'd6);
    for (int i = 0; i < got; i++) begin
      chk($sformatf("contention_data%0d", i), 32'(got_d[i]), 32'(exp_d[i]));
      chk($sformatf("contention_gid%0d", i), 32'(got_g[i]), 32'(exp_g[i]));
    end

    // busy blocking
    do_reset();
    busy_drv = 1'b1; req1_valid = 1'b1; req1_data = 8'h77;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (req0_ready || req1_ready || uart_load) bad++;
    end
    chk("busy_block_quiet", 32'(bad), 32'd0);
    busy_drv = 1'b0;
    step();
    chk("busy_release_accept", 32'({req1_ready, uart_data, grant_id}), 32'({1'b1, 8'h77, 1'b1}));
    req1_valid = 1'b0;
    step();
    chk("busy_release_load", 32'(uart_load), 32'd1);

    // timeout (ACK_TIMEOUT=8), then set-vs-clear priority
    do_reset();
    req0_valid = 1'b1; req0_data = 8'hA5;
    step();
    chk("timeout_accept", 32'({req0_ready, uart_data}), 32'({1'b1, 8'hA5}));
    req0_valid = 1'b0;
    hi = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (uart_load) hi++;
      else if (hi > 0) break;
    end
    chk("timeout_load_cycles", 32'(hi), 32'd8);
    chk("timeout_err_idle", 32'({ack_err, idle}), 32'b11);
    req1_valid = 1'b1; req1_data = 8'h5A;
    step();
    chk("after_timeout_accept", 32'({req1_ready, uart_data, ack_err}), 32'({1'b1, 8'h5A, 1'b1}));
    req1_valid = 1'b0; ack_err_clr = 1'b1;
    step();
    chk("err_clear", 32'(ack_err), 32'd0);
    hi = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (uart_load) hi++;
      else if (hi > 0) break;
    end
    chk("set_beats_clear", 32'({ack_err, hi[3:0]}), 32'({1'b1, 4'd7}));
    step();
    chk("err_clear_again", 32'(ack_err), 32'd0);
    ack_err_clr = 1'b0;

    // asynchronous reset while in LOAD
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h55;
    step();
    req0_valid = 1'b0;
    step();
    chk("pre_reset_load", 32'({uart_load, uart_data}), 32'({1'b1, 8'h55}));
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(obs()), 32'({3'b000, 8'h00, 3'b010}));
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (req0_ready || req1_ready || !idle) bad++;
    end
    chk("post_reset_quiet", 32'(bad), 32'd0);
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    step();
    chk("post_reset_favours_req0", 32'({req0_ready, req1_ready, uart_data}),
        32'({1'b1, 1'b0, 8'h11}));
    req0_valid = 1'b0; req1_valid = 1'b0;

    // request withdrawn while the transmitter is sending
    do_reset();
    tx_en = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h10;
    step();
    req0_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (uart_busy && !uart_load && !idle) begin
        found = 1;
        break;
      end
    end
    chk("reach_send", 32'(found), 32'd1);
    req1_valid = 1'b1; req1_data = 8'h99;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      req1_valid = 1'b0;
      if (req1_ready || uart_load || uart_data == 8'h99) bad++;
    end
    chk("withdrawn_never_sent", 32'({bad[7:0], idle}), 32'({8'd0, 1'b1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/atx_arbiter.md
Name: atx_arbiter

Overview:
- Shares the single async UART transmitter between two byte sources: the CPU output port (requester 0) and a hardware trace/debug source (requester 1).
- Arbitrates round-robin between them and runs the transmitter's load/busy handshake in hardware. Software no longer spins on busy in putchar.
- Sits between the CPU's atx_data/atx_ctrl I/O registers (plus the trace source) and the UART transmitter core.

Parameters:
- DATA_WIDTH, 8: byte width carried to the transmitter.
- ACK_TIMEOUT, 255: clk cycles to wait for uart_busy to rise after load before aborting; minimum 1.
- TMR_WIDTH, 8: timeout counter width; must satisfy 2^TMR_WIDTH > ACK_TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  CPU has a byte.
- req0_data  in  DATA_WIDTH  CPU byte.
- req0_ready  out  1  one-cycle pulse: CPU byte accepted.
- req1_valid  in  1  trace source has a byte.
- req1_data  in  DATA_WIDTH  trace byte.
- req1_ready  out  1  one-cycle pulse: trace byte accepted.
- uart_busy  in  1  transmitter busy; already synchronised to clk.
- uart_load  out  1  load request to transmitter.
- uart_data  out  DATA_WIDTH  byte presented to transmitter.
- grant_id  out  1  requester owning the current transfer.
- idle  out  1  high in IDLE state.
- ack_err  out  1  sticky: a load was never acknowledged.
- ack_err_clr  in  1  clears ack_err.

Behaviour:
- Reset is asynchronous and active-high: clk is the only clock; reset acts immediately, independent of clk.
- Reset values:
  - uart_load=0, uart_data=0, req0_ready=0, req1_ready=0, grant_id=0, idle=1, ack_err=0.
  - Round-robin pointer favours requester 0 first; timer=0.
- IDLE:
  - Accepts only when uart_busy=0 and at least one valid is high.
  - Winner: the only valid requester; if both are valid, the one not granted last.
  - On accept, same edge: latch winner data into uart_data, set grant_id, pulse winner's reqN_ready for exactly 1 cycle, flip the pointer, go to LOAD.
  - If uart_busy=1, stay in IDLE and give no ready, even with valid high.
- LOAD:
  - uart_load=1, idle=0; timer counts up from 0.
  - uart_busy=1 sampled -> uart_load=0 on the next cycle, go to SEND.
  - Timer reaches ACK_TIMEOUT with busy still 0 -> uart_load=0, set ack_err, return to IDLE; the byte is dropped.
- SEND: wait for uart_busy=0, then return to IDLE. No new accept happens in the cycle of that return.
- Latency: valid to ready is 1 clk edge when IDLE and the transmitter is idle. Load rises the cycle after ready.
- Data stability:
  - uart_data is held constant from accept until the next accept.
  - Requester data may change after its ready pulse.
- Handshake rules:
  - A requester holds valid and data until its ready pulse.
  - Dropping valid before ready is legal; that byte is then never sent.
- ack_err and ack_err_clr:
  - ack_err_clr takes effect the cycle after it is sampled.
  - If a timeout and ack_err_clr occur in the same cycle, the set wins.
- Pointer update: the pointer only changes on accept. A single requester streaming back-to-back keeps being served.
- Reset mid-transfer: uart_load drops immediately (asynchronously); the in-flight byte is lost and no ready is re-issued.
- Illegal state encodings recover to IDLE.

Test Plan:
- Single byte: req0_valid=1, data=0x41, busy idle; transmitter model raises busy 3 cycles after load and holds it 10 cycles -> req0_ready pulses once; uart_load high exactly 4 cycles; uart_data=0x41, grant_id=0; idle returns 1 cycle after busy falls.
- Contention: both valid continuously, req0 sends 0x30,0x31,0x32 and req1 sends 0x61,0x62,0x63 -> uart_data sequence 0x30,0x61,0x31,0x62,0x32,0x63, alternating grant_id.
- Busy blocking: uart_busy forced 1 while req1_valid=1 for 20 cycles -> no ready and no load; after busy falls, accept occurs on the next edge.
- Timeout: ACK_TIMEOUT=8, busy never rises -> uart_load high for 8 cycles then 0; ack_err=1; next byte still served. Asserting ack_err_clr clears ack_err.
- Async reset: reset asserted while in LOAD with data 0x55 -> uart_load drops without a clock edge. After release: idle=1, pointer favours req0, no ready pulse.
- Withdrawn request: req1_valid pulsed 1 cycle while the arbiter is in SEND -> no req1_ready, and the byte is never transmitted.
